// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder
//   System-bus memory responder. It accepts 64-byte line reads and writes and
//   keeps the line data in a word-addressed array. Read data goes back as eight
//   64-bit beats in line order (word 0 first) under the response handshake.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   bus_reqcyc   request valid (address cycle or write data beat)
//   bus_req      address on the address cycle, write data on data beats
//   bus_reqtag   request tag (13'h1100 line read, 13'h0100 line write)
//   bus_reqack   one-cycle pulse in the cycle after a request is captured
//   bus_respcyc  response beat valid
//   bus_resp     response data, 0 while bus_respcyc is low
//   bus_resptag  13'h1100 while bus_respcyc is high, 0 otherwise
//   bus_respack  initiator accepts the current beat
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_LINES      = 256,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int LINE_AW = $clog2(MEM_LINES);

  localparam logic [BUS_TAG_WIDTH-1:0] TAG_READ  = BUS_TAG_WIDTH'(13'h1100);
  localparam logic [BUS_TAG_WIDTH-1:0] TAG_WRITE = BUS_TAG_WIDTH'(13'h0100);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WDATA = 2'd1;
  localparam logic [1:0] DELAY = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Last DELAY count value; unused when LATENCY is 0 (DELAY is skipped).
  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  logic [1:0]         state_reg, state_next;
  logic [2:0]         beat_reg, beat_next;
  logic [3:0]         dly_reg, dly_next;
  logic [LINE_AW-1:0] line_reg, line_next;
  logic               ack_reg, ack_next;

  logic [LINE_AW-1:0] req_line;
  logic [LINE_AW-1:0] rd_line;
  logic               beat_wr;
  logic               commit;
  logic [BUS_DATA_WIDTH-1:0] rd_words [8];

  // Word offset addr[5:3] is dropped and bits above the array size wrap.
  assign req_line = bus_req[LINE_AW+5:6];

  assign beat_wr = (state_reg == WDATA) && bus_reqcyc;
  assign commit  = beat_wr && (beat_reg == 3'd7);

  // In IDLE the array is read speculatively at the incoming address, so beat 0
  // is already registered the cycle after capture (needed for LATENCY=0).
  assign rd_line = (state_reg == IDLE) ? req_line : line_reg;

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    dly_next   = dly_reg;
    line_next  = line_reg;
    ack_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus_reqcyc && (bus_reqtag == TAG_READ)) begin
          line_next  = req_line;
          ack_next   = 1'b1;
          beat_next  = 3'd0;
          dly_next   = 4'd0;
          state_next = (LATENCY == 0) ? RESP : DELAY;
        end else if (bus_reqcyc && (bus_reqtag == TAG_WRITE)) begin
          line_next  = req_line;
          ack_next   = 1'b1;
          beat_next  = 3'd0;
          state_next = WDATA;
        end
      end
      WDATA: begin
        if (bus_reqcyc) begin
          beat_next = beat_reg + 3'd1;
          if (beat_reg == 3'd7) state_next = IDLE;
        end
      end
      DELAY: begin
        if (dly_reg == LAT_LAST) begin
          state_next = RESP;
          beat_next  = 3'd0;
        end else begin
          dly_next = dly_reg + 4'd1;
        end
      end
      RESP: begin
        if (bus_respack) begin
          beat_next = beat_reg + 3'd1;
          if (beat_reg == 3'd7) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      beat_reg  <= 3'd0;
      dly_reg   <= 4'd0;
      line_reg  <= '0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      dly_reg   <= dly_next;
      line_reg  <= line_next;
      ack_reg   <= ack_next;
    end
  end

  // One bank per word position of a line, so a whole line commits in a single
  // edge. Word 7 is written straight from the bus on the final beat; words
  // 0..6 come from the staging buffer. Array contents are never reset.
  for (genvar gi = 0; gi < 8; gi++) begin : g_bank
    logic [BUS_DATA_WIDTH-1:0] bank_mem [MEM_LINES];
    logic [BUS_DATA_WIDTH-1:0] rd_word_reg;
    logic [BUS_DATA_WIDTH-1:0] wr_word;

    if (gi < 7) begin : g_stage
      logic [BUS_DATA_WIDTH-1:0] wbuf_reg;
      always_ff @(posedge clk) begin
        if (beat_wr && (beat_reg == 3'(gi))) wbuf_reg <= bus_req;
      end
      assign wr_word = wbuf_reg;
    end else begin : g_direct
      assign wr_word = bus_req;
    end

    always_ff @(posedge clk) begin
      if (commit) bank_mem[line_reg] <= wr_word;
      rd_word_reg <= bank_mem[rd_line];
    end

    assign rd_words[gi] = rd_word_reg;
  end

  // Outputs decode from reset-cleared state, so they drop to 0 as soon as
  // reset asserts.
  assign bus_reqack  = ack_reg;
  assign bus_respcyc = (state_reg == RESP);
  assign bus_resp    = bus_respcyc ? rd_words[beat_reg] : '0;
  assign bus_resptag = bus_respcyc ? TAG_READ : '0;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Testbench for sysbus_mem_responder: two instances (LATENCY 4 and 0) share
// one stimulus bus; the request valid is steered to the selected instance.
// A line-level memory model checks every beat and handshake cycle.
module tb_sysbus_mem_responder;

  localparam int MEM_LINES = 256;
  localparam int LAT_A     = 4;
  localparam logic [12:0] TAG_RD = 13'h1100;
  localparam logic [12:0] TAG_WR = 13'h0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reqcyc = 1'b0;
  logic [63:0] req = '0;
  logic [12:0] reqtag = '0;
  logic        respack = 1'b0;
  logic        sel = 1'b0;

  logic        reqcyc_a, reqcyc_b;
  logic        ack_a, ack_b, respcyc_a, respcyc_b;
  logic [63:0] resp_a, resp_b;
  logic [12:0] resptag_a, resptag_b;

  logic        ack, respcyc;
  logic [63:0] resp;
  logic [12:0] resptag;

  int total = 0;
  int bad   = 0;

  logic [63:0] ref_mem [int];
  logic [63:0] wd [8];

  always #5 clk = ~clk;

  assign reqcyc_a = reqcyc & ~sel;
  assign reqcyc_b = reqcyc & sel;
  assign ack      = sel ? ack_b     : ack_a;
  assign respcyc  = sel ? respcyc_b : respcyc_a;
  assign resp     = sel ? resp_b    : resp_a;
  assign resptag  = sel ? resptag_b : resptag_a;

  sysbus_mem_responder #(.MEM_LINES(MEM_LINES), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .reset(reset), .bus_reqcyc(reqcyc_a), .bus_req(req),
    .bus_reqtag(reqtag), .bus_reqack(ack_a), .bus_respcyc(respcyc_a),
    .bus_resp(resp_a), .bus_resptag(resptag_a), .bus_respack(respack)
  );

  sysbus_mem_responder #(.MEM_LINES(MEM_LINES), .LATENCY(0)) u_dut_b (
    .clk(clk), .reset(reset), .bus_reqcyc(reqcyc_b), .bus_req(req),
    .bus_reqtag(reqtag), .bus_reqack(ack_b), .bus_respcyc(respcyc_b),
    .bus_resp(resp_b), .bus_resptag(resptag_b), .bus_respack(respack)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model key: one word slot per (instance, line, word); address wraps by line.
  function automatic int key(input logic s, input logic [63:0] addr, input int k);
    return (s ? MEM_LINES * 8 : 0) + int'((addr >> 6) % MEM_LINES) * 8 + k;
  endfunction

  // Called at #1 after a rising edge: reset mid-cycle, check outputs at once.
  task automatic reset_now();
    reset = 1'b0; reqcyc = 1'b0; respack = 1'b0;
    #1;
    check("rst_respcyc", 64'(respcyc), 64'd0);
    check("rst_resp", resp, 64'd0);
    check("rst_resptag", 64'(resptag), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic s, input logic [63:0] addr, input int stall_after,
                          input int abort_after, input bit rnd_stall);
    int n = 0;
    int cyc = 1;
    int pend = 0;
    sel = s; reqcyc = 1'b1; req = addr; reqtag = TAG_WR; respack = 1'($urandom);
    @(posedge clk); #1;
    while (n < 8 && cyc < 200) begin
      check("wr_ack", 64'(ack), 64'(cyc == 1));
      check("wr_respcyc", 64'(respcyc), 64'd0);
      if (n == abort_after) begin
        $display("wr  dut=%0d addr=%h aborted by reset after %0d beats", s, addr, n);
        reset_now();
        return;
      end
      if (pend > 0 || (rnd_stall && $urandom_range(0, 3) == 0)) begin
        reqcyc = 1'b0;
        req = {$urandom, $urandom};
        if (pend > 0) pend--;
      end else begin
        reqcyc = 1'b1;
        req = wd[n];
        reqtag = 13'($urandom);
        if (n == stall_after) pend = 2;
        n++;
      end
      respack = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    reqcyc = 1'b0; reqtag = '0; respack = 1'b0;
    if (n < 8) check("wr_timeout", 64'(n), 64'd8);
    check("wr_done_ack", 64'(ack), 64'd0);
    for (int k = 0; k < 8; k++) ref_mem[key(s, addr, k)] = wd[k];
    $display("wr  dut=%0d addr=%h cycles=%0d", s, addr, cyc);
  endtask

  // mode 0: respack held high; 1: pattern 1,0,0,...; 2: random.
  task automatic do_read(input logic s, input logic [63:0] addr, input int mode,
                         input int abort_beat, input bit inject);
    logic [63:0] exp [8];
    int lat;
    int beat = 0;
    int cyc = 1;
    int rk = 0;
    for (int k = 0; k < 8; k++)
      exp[k] = ref_mem.exists(key(s, addr, k)) ? ref_mem[key(s, addr, k)] : 64'd0;
    lat = s ? 0 : LAT_A;
    sel = s; reqcyc = 1'b1; req = addr; reqtag = TAG_RD; respack = 1'b0;
    @(posedge clk); #1;
    while (beat < 8 && cyc < 200) begin
      check("rd_ack", 64'(ack), 64'(cyc == 1));
      if (cyc <= lat) begin
        check("rd_wait_respcyc", 64'(respcyc), 64'd0);
        check("rd_wait_resp", resp, 64'd0);
        respack = 1'($urandom);
      end else begin
        check("rd_respcyc", 64'(respcyc), 64'd1);
        check("rd_resptag", 64'(resptag), 64'(TAG_RD));
        check("rd_beat", resp, exp[beat]);
        if (beat == abort_beat) begin
          $display("rd  dut=%0d addr=%h aborted by reset at beat %0d", s, addr, beat);
          reset_now();
          return;
        end
        case (mode)
          0: respack = 1'b1;
          1: respack = (rk % 3 == 0);
          default: respack = 1'($urandom);
        endcase
        rk++;
      end
      if (inject) begin
        reqcyc = 1'($urandom);
        req = {$urandom, $urandom};
        reqtag = $urandom_range(0, 1) ? TAG_RD : TAG_WR;
      end else begin
        reqcyc = 1'b0;
      end
      @(posedge clk); #1;
      if (cyc > lat && respack) beat++;
      cyc++;
    end
    reqcyc = 1'b0; reqtag = '0; respack = 1'b0;
    if (beat < 8) check("rd_timeout", 64'(beat), 64'd8);
    check("rd_end_respcyc", 64'(respcyc), 64'd0);
    check("rd_end_resp", resp, 64'd0);
    check("rd_end_resptag", 64'(resptag), 64'd0);
    check("rd_end_ack", 64'(ack), 64'd0);
    $display("rd  dut=%0d addr=%h mode=%0d cycles=%0d", s, addr, mode, cyc);
  endtask

  task automatic idle_junk(input logic s, input logic [12:0] t);
    sel = s; reqcyc = 1'b1; req = {$urandom, $urandom}; reqtag = t;
    @(posedge clk); #1;
    reqcyc = 1'b0; reqtag = '0;
    check("junk_ack", 64'(ack), 64'd0);
    check("junk_respcyc", 64'(respcyc), 64'd0);
    @(posedge clk); #1;
    check("junk_ack2", 64'(ack), 64'd0);
    $display("junk dut=%0d tag=%h", s, t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [12:0] t;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack_a", 64'(ack_a), 64'd0);
    check("reset_respcyc_a", 64'(respcyc_a), 64'd0);
    check("reset_resp_a", resp_a, 64'd0);
    check("reset_resptag_a", 64'(resptag_a), 64'd0);
    check("reset_ack_b", 64'(ack_b), 64'd0);
    check("reset_respcyc_b", 64'(respcyc_b), 64'd0);
    check("reset_resp_b", resp_b, 64'd0);
    check("reset_resptag_b", 64'(resptag_b), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Background contents for lines 0..15 of both instances.
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 16; l++) begin
        for (int k = 0; k < 8; k++) wd[k] = {$urandom, $urandom};
        do_write(1'(s), 64'(l * 64), -1, 8, 1'b0);
      end

    // Basic write/read of line 0x1000, then a stalled-ack read.
    for (int k = 0; k < 8; k++) wd[k] = 64'h11 + 64'(k);
    do_write(1'b0, 64'h1000, -1, 8, 1'b0);
    do_read(1'b0, 64'h1000, 0, -1, 1'b0);
    do_read(1'b0, 64'h1000, 1, -1, 1'b0);

    // Write with a 2-cycle stall after beat 3, then an aliasing write.
    for (int k = 0; k < 8; k++) wd[k] = {$urandom, $urandom};
    do_write(1'b0, 64'h1000, 3, 8, 1'b0);
    do_read(1'b0, 64'h1000, 0, -1, 1'b0);
    for (int k = 0; k < 8; k++) wd[k] = {$urandom, $urandom};
    do_write(1'b0, 64'h1000 + 64'(MEM_LINES * 64), -1, 8, 1'b0);
    do_read(1'b0, 64'h1028, 2, -1, 1'b0);

    // Ignored tags in IDLE and requests injected while busy.
    idle_junk(1'b0, 13'h0000);
    for (int i = 0; i < 3; i++) begin
      t = 13'($urandom);
      if (t == TAG_RD || t == TAG_WR) t = 13'h1fff;
      idle_junk(1'b0, t);
    end
    do_read(1'b0, 64'h1000, 1, -1, 1'b1);

    // Reset during read beat 4, and after 5 write beats.
    do_read(1'b0, 64'h1000, 0, 4, 1'b0);
    for (int k = 0; k < 8; k++) wd[k] = {$urandom, $urandom};
    do_write(1'b0, 64'h1000, -1, 5, 1'b0);
    do_read(1'b0, 64'h1000, 0, -1, 1'b0);

    // Zero-latency instance.
    for (int k = 0; k < 8; k++) wd[k] = 64'h21 + 64'(k);
    do_write(1'b1, 64'h1000, -1, 8, 1'b0);
    do_read(1'b1, 64'h1000, 0, -1, 1'b0);
    do_read(1'b1, 64'h1000, 1, -1, 1'b1);

    // Random mix over the preloaded lines with random upper/offset bits.
    for (int i = 0; i < 30; i++) begin
      a = {$urandom, $urandom};
      a[13:6] = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 8; k++) wd[k] = {$urandom, $urandom};
        do_write(1'($urandom), a, -1, 8, 1'b1);
      end else begin
        do_read(1'($urandom), a, 2, -1, 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
